// File: rtl/conv_pkg.sv
// Shared definitions for the convolver output path: state encoding, result width, pooled-map sizing.
package conv_pkg;

    localparam int unsigned CONV_N = 8;
    localparam int unsigned CONV_W = CONV_N + 10;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        EVEN_ROW = 2'd1,
        ODD_ROW  = 2'd2,
        DONE     = 2'd3
    } pool_state_t;

    function automatic int unsigned pool_dim(input int unsigned m);
        return m / 2;
    endfunction

    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pool_line_buf.sv
// Line buffer holding horizontal pair maxima of the current even row, one entry per pooled column.
module pool_line_buf
    import conv_pkg::*;
#(
    parameter int unsigned DEPTH = 13,
    parameter int unsigned W     = CONV_W,
    parameter int unsigned AW    = idx_w(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata_c
);

    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata_c = mem[raddr];

endmodule

// File: rtl/relu_maxpool.sv
// ReLU + 2x2/stride-2 max-pool + shift/saturate requantiser behind the convolver.
// Define RELU_MAXPOOL_ROUND_EN for round-half-up before the shift; default truncates.
module relu_maxpool
    import conv_pkg::*;
#(
    parameter int unsigned M     = 26,
    parameter int unsigned IW    = CONV_W,
    parameter int unsigned OW    = 8,
    parameter int unsigned SHIFT = 4
) (
    input  logic          clk,
    input  logic          global_rst,
    input  logic [IW-1:0] in_data,
    input  logic          in_valid,
    input  logic          in_end,
    output logic [OW-1:0] out_data,
    output logic          out_valid,
    output logic          out_end,
    output logic          busy
);

    localparam int unsigned PD = pool_dim(M);
    localparam int unsigned CW = idx_w(M);
    localparam int unsigned AW = idx_w(PD);
    localparam logic [IW:0] SAT_MAX = (IW+1)'((1 << OW) - 1);
`ifdef RELU_MAXPOOL_ROUND_EN
    localparam logic [IW:0] RND = (IW+1)'((1 << SHIFT) >> 1);
`else
    localparam logic [IW:0] RND = '0;
`endif

    pool_state_t   state;
    logic [CW-1:0] col, row, col_nxt, row_nxt;
    logic [IW-1:0] hold, relu, pair_max, lbuf_rd, pool_max;
    logic [IW:0]   rounded, shifted;
    logic [OW-1:0] sat;
    logic          take, in_pair, lbuf_we;

    // Datapath: ReLU makes every later comparison unsigned
    always_comb begin
        relu     = in_data[IW-1] ? '0 : in_data;
        pair_max = (relu > hold) ? relu : hold;
        pool_max = (lbuf_rd > pair_max) ? lbuf_rd : pair_max;
        rounded  = {1'b0, pool_max} + RND;
        shifted  = rounded >> SHIFT;
        sat      = (shifted > SAT_MAX) ? '1 : shifted[OW-1:0];
        take     = in_valid && (state != DONE);
        in_pair  = (32'(col) < 2*PD) && (32'(row) < 2*PD);
        lbuf_we  = take && in_pair && col[0] && !row[0];
        if (col == CW'(M-1)) begin
            col_nxt = '0;
            row_nxt = (row == CW'(M-1)) ? '0 : row + CW'(1);
        end else begin
            col_nxt = col + CW'(1);
            row_nxt = row;
        end
    end

    pool_line_buf #(
        .DEPTH (PD),
        .W     (IW),
        .AW    (AW)
    ) u_lbuf (
        .clk     (clk),
        .we      (lbuf_we),
        .waddr   (AW'(col >> 1)),
        .wdata   (pair_max),
        .raddr   (AW'(col >> 1)),
        .rdata_c (lbuf_rd)
    );

    always_ff @(posedge clk or posedge global_rst) begin
        if (global_rst) begin
            state     <= IDLE;
            col       <= '0;
            row       <= '0;
            hold      <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            out_end   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            out_end   <= 1'b0;
            if (take) begin
                col <= col_nxt;
                row <= row_nxt;
                if (in_pair && !col[0]) hold <= relu;
                if (in_pair && col[0] && row[0]) begin
                    out_data  <= sat;
                    out_valid <= 1'b1;
                end
            end
            // Counter clear on in_end overrides the sample's own advance
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        state <= row_nxt[0] ? ODD_ROW : EVEN_ROW;
                        busy  <= 1'b1;
                    end
                end
                EVEN_ROW, ODD_ROW: begin
                    if (in_end) begin
                        state   <= DONE;
                        col     <= '0;
                        row     <= '0;
                        out_end <= 1'b1;
                    end else if (in_valid) begin
                        state <= row_nxt[0] ? ODD_ROW : EVEN_ROW;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_relu_maxpool.sv
// Directed bench for relu_maxpool: three instances (M=4/SHIFT=0, M=4/SHIFT=4, M=5/SHIFT=0) share stimulus.
module tb_relu_maxpool;

    logic        clk = 1'b0;
    logic        global_rst;
    logic [17:0] in_data;
    logic        in_valid, in_end;
    logic [7:0]  od0, od1, od2;
    logic        ov0, ov1, ov2, oe0, oe1, oe2, b0, b1, b2;

    always #5 clk = ~clk;

    relu_maxpool #(.M(4), .IW(18), .OW(8), .SHIFT(0)) u_m4s0 (
        .clk(clk), .global_rst(global_rst), .in_data(in_data), .in_valid(in_valid), .in_end(in_end),
        .out_data(od0), .out_valid(ov0), .out_end(oe0), .busy(b0));
    relu_maxpool #(.M(4), .IW(18), .OW(8), .SHIFT(4)) u_m4s4 (
        .clk(clk), .global_rst(global_rst), .in_data(in_data), .in_valid(in_valid), .in_end(in_end),
        .out_data(od1), .out_valid(ov1), .out_end(oe1), .busy(b1));
    relu_maxpool #(.M(5), .IW(18), .OW(8), .SHIFT(0)) u_m5s0 (
        .clk(clk), .global_rst(global_rst), .in_data(in_data), .in_valid(in_valid), .in_end(in_end),
        .out_data(od2), .out_valid(ov2), .out_end(oe2), .busy(b2));

    int cyc = 0;
    int qd0[$], qc0[$], ec0[$];
    int qd1[$], qc1[$], ec1[$];
    int qd2[$], qc2[$], ec2[$];
    int n_checks = 0;
    int n_pass = 0;
    int frame[25];
    int dcyc[25];
    int end_cyc;

    // Output recorder: cycle index and data of every out_valid / out_end pulse
    always @(posedge clk) begin
        #1;
        cyc++;
        if (ov0) begin qd0.push_back(int'(od0)); qc0.push_back(cyc); end
        if (ov1) begin qd1.push_back(int'(od1)); qc1.push_back(cyc); end
        if (ov2) begin qd2.push_back(int'(od2)); qc2.push_back(cyc); end
        if (oe0) ec0.push_back(cyc);
        if (oe1) ec1.push_back(cyc);
        if (oe2) ec2.push_back(cyc);
    end

    task automatic drive(input int d, input logic v, input logic e, output int c);
        @(negedge clk);
        in_data  = 18'(d);
        in_valid = v;
        in_end   = e;
        c = cyc;
    endtask

    task automatic idle(input int n);
        int c;
        for (int i = 0; i < n; i++) drive(0, 1'b0, 1'b0, c);
    endtask

    task automatic clear_q();
        qd0.delete(); qc0.delete(); ec0.delete();
        qd1.delete(); qc1.delete(); ec1.delete();
        qd2.delete(); qc2.delete(); ec2.delete();
    endtask

    task automatic do_reset();
        global_rst = 1'b1;
        in_valid = 1'b0;
        in_end = 1'b0;
        in_data = '0;
        idle(2);
        global_rst = 1'b0;
        idle(1);
        clear_q();
    endtask

    task automatic send_frame(input int n, input int gap_pct);
        int c;
        for (int i = 0; i < n; i++) begin
            if (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) idle(1 + $urandom_range(0, 1));
            drive(frame[i], 1'b1, 1'b0, c);
            dcyc[i] = c;
        end
        drive(0, 1'b0, 1'b0, c);
        drive(0, 1'b0, 1'b1, c);
        end_cyc = c;
        idle(3);
    endtask

    task automatic test_reset();
        global_rst = 1'b1;
        in_valid = 1'b0;
        in_end = 1'b0;
        in_data = '0;
        @(negedge clk);
        n_checks++;
        if ({od0, ov0, oe0, b0} !== 17'd0) $display("FAIL reset_m4s0: got %h want 0", {od0, ov0, oe0, b0});
        else n_pass++;
        n_checks++;
        if ({od1, ov1, oe1, b1} !== 17'd0) $display("FAIL reset_m4s4: got %h want 0", {od1, ov1, oe1, b1});
        else n_pass++;
        n_checks++;
        if ({od2, ov2, oe2, b2} !== 17'd0) $display("FAIL reset_m5s0: got %h want 0", {od2, ov2, oe2, b2});
        else n_pass++;
        do_reset();
    endtask

    task automatic test_basic();
        int exp_d[4] = '{6, 8, 14, 16};
        int pos[4] = '{5, 7, 13, 15};
        do_reset();
        for (int i = 0; i < 16; i++) frame[i] = i + 1;
        send_frame(16, 0);
        n_checks++;
        if (qd0.size() !== 4) $display("FAIL basic_count: got %0d want 4", qd0.size());
        else n_pass++;
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (k >= qd0.size() || qd0[k] !== exp_d[k])
                $display("FAIL basic_data[%0d]: got %0d want %0d", k, (k < qd0.size()) ? qd0[k] : -1, exp_d[k]);
            else n_pass++;
            n_checks++;
            if (k >= qc0.size() || qc0[k] !== dcyc[pos[k]] + 1)
                $display("FAIL basic_latency[%0d]: got cycle %0d want %0d", k, (k < qc0.size()) ? qc0[k] : -1, dcyc[pos[k]] + 1);
            else n_pass++;
        end
        n_checks++;
        if (ec0.size() !== 1 || ec0[0] !== end_cyc + 1)
            $display("FAIL basic_out_end: got %0d pulses first at %0d want 1 at %0d", ec0.size(), (ec0.size() > 0) ? ec0[0] : -1, end_cyc + 1);
        else n_pass++;
        n_checks++;
        if (b0 !== 1'b0) $display("FAIL basic_busy_after: got %b want 0", b0);
        else n_pass++;
    endtask

    task automatic test_relu();
        int exp_m[4] = '{3, 0, 0, 0};
        do_reset();
        for (int i = 0; i < 16; i++) frame[i] = -5;
        send_frame(16, 0);
        n_checks++;
        if (qd0.size() !== 4) $display("FAIL relu_neg_count: got %0d want 4", qd0.size());
        else n_pass++;
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (k >= qd0.size() || qd0[k] !== 0)
                $display("FAIL relu_neg_data[%0d]: got %0d want 0", k, (k < qd0.size()) ? qd0[k] : -1);
            else n_pass++;
        end
        clear_q();
        frame[0] = -100; frame[1] = 3; frame[4] = -1; frame[5] = 2;
        send_frame(16, 0);
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (k >= qd0.size() || qd0[k] !== exp_m[k])
                $display("FAIL relu_mixed[%0d]: got %0d want %0d", k, (k < qd0.size()) ? qd0[k] : -1, exp_m[k]);
            else n_pass++;
        end
    endtask

    task automatic test_shift_sat();
        int exp_sat[4] = '{255, 7, 40, 0};
`ifdef RELU_MAXPOOL_ROUND_EN
        int exp_sh[4] = '{19, 0, 3, 0};
`else
        int exp_sh[4] = '{18, 0, 2, 0};
`endif
        do_reset();
        for (int i = 0; i < 16; i++) frame[i] = 0;
        frame[0] = 300; frame[2] = 5; frame[3] = 7; frame[8] = 40; frame[15] = -3;
        send_frame(16, 0);
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (k >= qd1.size() || qd1[k] !== exp_sh[k])
                $display("FAIL shift4[%0d]: got %0d want %0d", k, (k < qd1.size()) ? qd1[k] : -1, exp_sh[k]);
            else n_pass++;
            n_checks++;
            if (k >= qd0.size() || qd0[k] !== exp_sat[k])
                $display("FAIL saturate[%0d]: got %0d want %0d", k, (k < qd0.size()) ? qd0[k] : -1, exp_sat[k]);
            else n_pass++;
        end
    endtask

    task automatic test_gaps();
        int exp_d[4] = '{6, 8, 14, 16};
        int pos[4] = '{5, 7, 13, 15};
        do_reset();
        for (int i = 0; i < 16; i++) frame[i] = i + 1;
        send_frame(16, 30);
        n_checks++;
        if (qd0.size() !== 4) $display("FAIL gaps_count: got %0d want 4", qd0.size());
        else n_pass++;
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (k >= qd0.size() || qd0[k] !== exp_d[k] || qc0[k] !== dcyc[pos[k]] + 1)
                $display("FAIL gaps_out[%0d]: got %0d at %0d want %0d at %0d", k,
                         (k < qd0.size()) ? qd0[k] : -1, (k < qc0.size()) ? qc0[k] : -1, exp_d[k], dcyc[pos[k]] + 1);
            else n_pass++;
        end
    endtask

    task automatic test_odd_m();
        int exp_d[4] = '{7, 9, 17, 19};
        int pos[4] = '{6, 8, 16, 18};
        do_reset();
        for (int i = 0; i < 25; i++) frame[i] = i + 1;
        send_frame(25, 0);
        n_checks++;
        if (qd2.size() !== 4) $display("FAIL odd_m_count: got %0d want 4", qd2.size());
        else n_pass++;
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (k >= qd2.size() || qd2[k] !== exp_d[k] || qc2[k] !== dcyc[pos[k]] + 1)
                $display("FAIL odd_m_out[%0d]: got %0d at %0d want %0d at %0d", k,
                         (k < qd2.size()) ? qd2[k] : -1, (k < qc2.size()) ? qc2[k] : -1, exp_d[k], dcyc[pos[k]] + 1);
            else n_pass++;
        end
        n_checks++;
        if (ec2.size() !== 1 || ec2[0] !== end_cyc + 1)
            $display("FAIL odd_m_out_end: got %0d pulses want 1 at %0d", ec2.size(), end_cyc + 1);
        else n_pass++;
    endtask

    task automatic test_partial_frame();
        int exp_d[4] = '{6, 8, 14, 16};
        do_reset();
        for (int i = 0; i < 16; i++) frame[i] = i + 1;
        send_frame(8, 0);
        n_checks++;
        if (qd0.size() !== 2 || qd0[0] !== 6 || qd0[1] !== 8)
            $display("FAIL partial_outputs: got %0d outputs first %0d want 2 outputs 6,8",
                     qd0.size(), (qd0.size() > 0) ? qd0[0] : -1);
        else n_pass++;
        n_checks++;
        if (ec0.size() !== 1 || ec0[0] !== end_cyc + 1)
            $display("FAIL partial_out_end: got %0d pulses want 1 at %0d", ec0.size(), end_cyc + 1);
        else n_pass++;
        clear_q();
        send_frame(16, 0);
        n_checks++;
        if (qd0.size() !== 4) $display("FAIL after_partial_count: got %0d want 4", qd0.size());
        else n_pass++;
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (k >= qd0.size() || qd0[k] !== exp_d[k])
                $display("FAIL after_partial_data[%0d]: got %0d want %0d", k, (k < qd0.size()) ? qd0[k] : -1, exp_d[k]);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid_frame();
        int c;
        do_reset();
        for (int i = 0; i < 6; i++) drive(i + 1, 1'b1, 1'b0, c);
        drive(0, 1'b0, 1'b0, c);
        n_checks++;
        if (ov0 !== 1'b1 || od0 !== 8'd6 || b0 !== 1'b1)
            $display("FAIL mid_before_rst: got valid=%b data=%0d busy=%b want 1,6,1", ov0, od0, b0);
        else n_pass++;
        global_rst = 1'b1;
        #1;
        n_checks++;
        if ({od0, ov0, oe0, b0} !== 17'd0 || b1 !== 1'b0 || b2 !== 1'b0)
            $display("FAIL mid_rst: got %h busy1=%b busy2=%b want 0", {od0, ov0, oe0, b0}, b1, b2);
        else n_pass++;
        idle(2);
        global_rst = 1'b0;
        idle(2);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_relu();
        test_shift_sat();
        test_gaps();
        test_odd_m();
        test_partial_frame();
        test_reset_mid_frame();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/relu_maxpool.md
Name: relu_maxpool

Overview:
- Downstream stage of the convolver. Consumes the convolver's raw MAC results (conv_op / valid_conv / end_conv).
- Applies ReLU, then 2x2 max-pooling with stride 2.
- Requantises each pooled value by right shift and saturation, producing OW-bit activations for the next layer.
- Output feature map is floor(M/2) x floor(M/2).

Parameters:
- M, 26, conv output map width = height (valid_conv pulses per row)
- IW, 18, input sample width (convolver N+10); two's complement signed
- OW, 8, output activation width; unsigned
- SHIFT, 4, requantisation right-shift amount (0..IW-1)

Ports:
- clk  in  1  clock
- global_rst  in  1  asynchronous, active-high reset
- in_data  in  IW  signed conv result; sampled only when in_valid=1
- in_valid  in  1  in_data qualifier (convolver valid_conv)
- in_end  in  1  end-of-frame pulse (convolver end_conv)
- out_data  out  OW  pooled, ReLU'd, requantised activation
- out_valid  out  1  one-cycle qualifier for out_data
- out_end  out  1  one-cycle end-of-frame pulse
- busy  out  1  high while a frame is in progress (state != IDLE)

Behaviour:
- Reset values: out_data=0, out_valid=0, out_end=0, busy=0; state=IDLE; col/row counters=0; hold register=0; line buffer contents don't-care.
- Counters advance only on in_valid. col runs 0..M-1, then wraps to 0 and row increments. row runs 0..M-1.
- Gaps (in_valid=0) are legal at any point; all state holds during a gap.
- ReLU: r = (in_data<0) ? 0 : in_data. Applied at input, so all comparisons are unsigned.
- States:
  - IDLE: first in_valid moves to EVEN_ROW.
  - EVEN_ROW: active while row[0]=0.
  - ODD_ROW: active while row[0]=1.
  - DONE: lasts one cycle, then returns to IDLE.
- Even row:
  - col even: hold <= r.
  - col odd: lbuf[col>>1] <= max(hold, r).
- Odd row:
  - col even: hold <= r.
  - col odd: p = max(hold, r, lbuf[col>>1]); out_data <= sat(p >> SHIFT); out_valid=1 the next cycle. Latency is 1 cycle from the qualifying input.
- sat(): if the value exceeds 2^OW-1, output 2^OW-1; otherwise output the low OW bits.
- Odd M: the last column (col=M-1) and last row (row=M-1) are consumed but produce no writes and no outputs.
- Row wrap from an odd row back to an even row reuses lbuf; no clearing is needed because every even-row entry is rewritten before it is read.
- in_end:
  - Any state except IDLE: go to DONE. out_end=1 in the cycle after in_end. Counters clear.
  - If in_end arrives before row M-1 completes, the partial frame is discarded: no further outputs, out_end still pulses.
  - In IDLE: in_end is ignored; no out_end.
- in_valid and in_end asserted in the same cycle: the sample is processed first, then the state moves to DONE.
- out_valid and out_end never assert in the same cycle, given the convolver's end_conv timing (end_conv follows its last valid by at least 1 cycle).
- global_rst mid-frame: immediate return to reset values; any in-flight output is lost.

Optional Feature:
- RELU_MAXPOOL_ROUND_EN defined: round half up before the shift, i.e. p' = p + (1<<(SHIFT-1)) when SHIFT>0, computed at IW+1 bits, then shift and saturate.
- Undefined: truncating shift.
- Latency is unchanged either way.

Decomposition:
- Shared package conv_pkg holds:
  - state encoding typedef (IDLE/EVEN_ROW/ODD_ROW/DONE)
  - conv result width constant (N+10)
  - localparam helpers for pooled map size floor(M/2)
- One sub-module, pool_line_buf: floor(M/2) x IW register array with 1 write port and 1 combinational read port, indexed by col>>1. No reset on data.

Test Plan:
- M=4, SHIFT=0: row-major input 1..16 with no gaps -> out_data 6, 8, 14, 16. Each appears 1 cycle after inputs 6, 8, 14, 16 respectively. out_end pulses 1 cycle after in_end.
- M=4: all inputs -5 -> four outputs of 0. Mixed window {-100, 3, -1, 2} -> 3.
- SHIFT=4, window max 300 -> 18 (truncate) or 19 (ROUND_EN). SHIFT=0, max 300 -> 255 (saturate).
- Same stimulus as test 1 with random in_valid gaps (30% idle) -> identical output sequence; out_valid count = 4.
- M=5: 25 inputs -> exactly 4 outputs. Col 4 and row 4 ignored.
- in_end after row 1 of M=4, then a full clean frame -> first frame gives 2 outputs plus out_end; second frame gives correct 4 outputs. global_rst asserted mid-frame -> all outputs 0 next edge, busy=0.
